// File: rtl/ahb_bm_pkg.sv
// Bus-matrix shared types and helpers.
// HTRANS codes, arbitration scheme ids, clog2.
package ahb_bm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ahb_mi_rr_arbiter_if.sv
// Arbiter <-> input-stage/MI signal bundle.
// slave: arbiter side, master: requester side.
interface ahb_mi_rr_arbiter_if #(
  parameter int NUM_PORTS = 3
);
  import ahb_bm_pkg::*;

  localparam int PW = clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0]   sel_op;
  logic [2*NUM_PORTS-1:0] trans_op;
  logic [NUM_PORTS-1:0]   mastlock_op;
  logic                   HREADYM;
  logic [PW-1:0]          addr_in_port;
  logic                   no_port;
  logic [NUM_PORTS-1:0]   active_op;
  logic [PW-1:0]          data_in_port;
  logic                   data_valid;

  modport slave (
    input  sel_op,
    input  trans_op,
    input  mastlock_op,
    input  HREADYM,
    output addr_in_port,
    output no_port,
    output active_op,
    output data_in_port,
    output data_valid
  );

  modport master (
    output sel_op,
    output trans_op,
    output mastlock_op,
    output HREADYM,
    input  addr_in_port,
    input  no_port,
    input  active_op,
    input  data_in_port,
    input  data_valid
  );

endinterface

// File: rtl/ahb_rr_pick.sv
// Rotating find-first: search ptr+1 .. N-1, then 0 .. ptr.
// The pointer itself is the lowest-priority candidate.
module ahb_rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] idx_o,
  output logic          none_o
);

  // Upper segment first, then wrap into the lower segment.
  always_comb begin
    idx_o  = ptr_i;
    none_o = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (none_o && req_i[i] && (PW'(i) > ptr_i)) begin
        idx_o  = PW'(i);
        none_o = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (none_o && req_i[i] && (PW'(i) <= ptr_i)) begin
        idx_o  = PW'(i);
        none_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ahb_mi_rr_arbiter.sv
// Round-robin arbiter for one MI output stage.
// Holds grant over bursts/locks, tracks data-phase owner.
module ahb_mi_rr_arbiter #(
  parameter int NUM_PORTS = 3
) (
  input logic                  HCLK,
  input logic                  HRESETn,
  ahb_mi_rr_arbiter_if.slave   bus
);
  import ahb_bm_pkg::*;

  localparam int PW = clog2(NUM_PORTS);

  logic [PW-1:0] addr_q, addr_d;
  logic [PW-1:0] dport_q, dport_d;
  logic          no_port_q, no_port_d;
  logic          lock_hold_q, lock_hold_d;
  logic          dvalid_q, dvalid_d;
  logic [PW-1:0] pick_idx;
  logic          pick_none;
  logic [1:0]    cur_trans;
  logic          cur_lock;
  logic          hold;

  ahb_rr_pick #(
    .N  (NUM_PORTS),
    .PW (PW)
  ) u_pick (
    .req_i  (bus.sel_op),
    .ptr_i  (addr_q),
    .idx_o  (pick_idx),
    .none_o (pick_none)
  );

  // Mux the granted port's HTRANS/HMASTLOCK; IDLE when ungranted.
  always_comb begin
    cur_trans = IDLE;
    cur_lock  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!no_port_q && (addr_q == PW'(i))) begin
        cur_trans = bus.trans_op[2*i +: 2];
        cur_lock  = bus.mastlock_op[i];
      end
    end
  end

  assign hold = !no_port_q &&
                (cur_trans == BUSY || cur_trans == SEQ ||
                 cur_lock || lock_hold_q);

  // Next state: everything advances only when the MI is ready.
  always_comb begin
    addr_d      = addr_q;
    no_port_d   = no_port_q;
    lock_hold_d = lock_hold_q;
    dport_d     = dport_q;
    dvalid_d    = dvalid_q;
    if (bus.HREADYM) begin
      lock_hold_d = cur_lock;
      dport_d     = addr_q;
      dvalid_d    = !no_port_q && cur_trans[1];
      if (!hold) begin
        addr_d    = pick_idx;
        no_port_d = pick_none;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      addr_q      <= '0;
      no_port_q   <= 1'b1;
      lock_hold_q <= 1'b0;
      dport_q     <= '0;
      dvalid_q    <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      no_port_q   <= no_port_d;
      lock_hold_q <= lock_hold_d;
      dport_q     <= dport_d;
      dvalid_q    <= dvalid_d;
    end
  end

  // One-hot grant flags back to the decoders.
  always_comb begin
    bus.active_op = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      bus.active_op[i] = !no_port_q && (addr_q == PW'(i));
    end
  end

  assign bus.addr_in_port = addr_q;
  assign bus.no_port      = no_port_q;
  assign bus.data_in_port = dport_q;
  assign bus.data_valid   = dvalid_q;

endmodule

// File: tb/tb_ahb_mi_rr_arbiter.sv
// Scoreboard bench for ahb_mi_rr_arbiter (3 ports).
// Driver queues expected outputs; negedge monitor compares.
module tb_ahb_mi_rr_arbiter;

  logic HCLK;
  logic HRESETn;

  ahb_mi_rr_arbiter_if #(.NUM_PORTS(3)) bus ();

  ahb_mi_rr_arbiter #(.NUM_PORTS(3)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus.slave)
  );

  typedef struct {
    int         id;
    logic       np;
    logic [1:0] addr;
    logic [2:0] act;
    logic [1:0] dp;
    logic       dv;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input int id,
                     input logic [7:0] got,
                     input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s step %0d got %0h want %0h",
               nm, id, got, want);
    end
  endtask

  // Monitor: pops one expectation per cycle when available.
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("no_port", e.id, 8'(bus.no_port), 8'(e.np));
        chk("addr_in_port", e.id, 8'(bus.addr_in_port), 8'(e.addr));
        chk("active_op", e.id, 8'(bus.active_op), 8'(e.act));
        chk("data_in_port", e.id, 8'(bus.data_in_port), 8'(e.dp));
        chk("data_valid", e.id, 8'(bus.data_valid), 8'(e.dv));
      end
    end
  end

  // Apply inputs for one cycle; queue outputs expected after the edge.
  task automatic step(input logic [2:0] sel,
                      input logic [5:0] tr,
                      input logic [2:0] lk,
                      input logic rdy,
                      input logic rstn,
                      input logic np,
                      input logic [1:0] addr,
                      input logic [2:0] act,
                      input logic [1:0] dp,
                      input logic dv);
    exp_t e;
    bus.sel_op      = sel;
    bus.trans_op    = tr;
    bus.mastlock_op = lk;
    bus.HREADYM     = rdy;
    HRESETn         = rstn;
    @(posedge HCLK);
    #1;
    step_id++;
    e.id   = step_id;
    e.np   = np;
    e.addr = addr;
    e.act  = act;
    e.dp   = dp;
    e.dv   = dv;
    q.push_back(e);
  endtask

  localparam logic [5:0] T_NS  = 6'b10_10_10;
  localparam logic [5:0] T_IDL = 6'b00_00_00;

  initial begin
    bus.sel_op      = '0;
    bus.trans_op    = '0;
    bus.mastlock_op = '0;
    bus.HREADYM     = 1'b1;
    HRESETn         = 1'b0;

    // Reset with all requesting, then rotating grants 1,2,0,1,2
    step(3'b111, T_NS, 3'b000, 1, 0, 1, 0, 3'b000, 0, 0);
    step(3'b111, T_NS, 3'b000, 1, 0, 1, 0, 3'b000, 0, 0);
    step(3'b111, T_NS, 3'b000, 1, 1, 0, 1, 3'b010, 0, 0);
    step(3'b111, T_NS, 3'b000, 1, 1, 0, 2, 3'b100, 1, 1);
    step(3'b111, T_NS, 3'b000, 1, 1, 0, 0, 3'b001, 2, 1);
    step(3'b111, T_NS, 3'b000, 1, 1, 0, 1, 3'b010, 0, 1);
    step(3'b111, T_NS, 3'b000, 1, 1, 0, 2, 3'b100, 1, 1);

    // Port 0 burst: NONSEQ then SEQ x3 holds grant
    step(3'b111, T_IDL, 3'b000, 1, 0, 1, 0, 3'b000, 0, 0);
    step(3'b001, 6'b00_00_10, 3'b000, 1, 1, 0, 0, 3'b001, 0, 0);
    step(3'b001, 6'b00_00_10, 3'b000, 1, 1, 0, 0, 3'b001, 0, 1);
    step(3'b111, 6'b10_10_11, 3'b000, 1, 1, 0, 0, 3'b001, 0, 1);
    step(3'b111, 6'b10_10_11, 3'b000, 1, 1, 0, 0, 3'b001, 0, 1);
    step(3'b111, 6'b10_10_11, 3'b000, 1, 1, 0, 0, 3'b001, 0, 1);
    step(3'b111, 6'b10_10_00, 3'b000, 1, 1, 0, 1, 3'b010, 0, 0);

    // Port 2 locked for 3 beats, held one more, then released
    step(3'b111, T_IDL, 3'b000, 1, 0, 1, 0, 3'b000, 0, 0);
    step(3'b100, 6'b10_00_00, 3'b000, 1, 1, 0, 2, 3'b100, 0, 0);
    step(3'b111, T_NS, 3'b100, 1, 1, 0, 2, 3'b100, 2, 1);
    step(3'b111, T_NS, 3'b100, 1, 1, 0, 2, 3'b100, 2, 1);
    step(3'b111, T_NS, 3'b100, 1, 1, 0, 2, 3'b100, 2, 1);
    step(3'b111, T_NS, 3'b000, 1, 1, 0, 2, 3'b100, 2, 1);
    step(3'b111, T_NS, 3'b000, 1, 1, 0, 0, 3'b001, 2, 1);

    // HREADYM low freezes everything while sel_op changes
    step(3'b111, T_IDL, 3'b000, 1, 0, 1, 0, 3'b000, 0, 0);
    step(3'b001, T_NS, 3'b000, 1, 1, 0, 0, 3'b001, 0, 0);
    step(3'b001, T_NS, 3'b000, 0, 1, 0, 0, 3'b001, 0, 0);
    step(3'b110, T_NS, 3'b000, 0, 1, 0, 0, 3'b001, 0, 0);
    step(3'b110, T_NS, 3'b000, 0, 1, 0, 0, 3'b001, 0, 0);
    step(3'b110, T_NS, 3'b000, 0, 1, 0, 0, 3'b001, 0, 0);
    step(3'b110, T_NS, 3'b000, 1, 1, 0, 1, 3'b010, 0, 1);

    // Reset mid-burst of port 1
    step(3'b111, T_IDL, 3'b000, 1, 0, 1, 0, 3'b000, 0, 0);
    step(3'b010, 6'b00_10_00, 3'b000, 1, 1, 0, 1, 3'b010, 0, 0);
    step(3'b111, 6'b10_11_10, 3'b000, 1, 1, 0, 1, 3'b010, 1, 1);
    step(3'b111, 6'b10_11_10, 3'b000, 1, 1, 0, 1, 3'b010, 1, 1);
    step(3'b111, 6'b10_11_10, 3'b000, 1, 0, 1, 0, 3'b000, 0, 0);
    step(3'b000, T_IDL, 3'b000, 1, 1, 1, 0, 3'b000, 0, 0);

    // Sole requester re-grant, release on drop, pointer kept, wrap
    step(3'b100, 6'b10_00_00, 3'b000, 1, 1, 0, 2, 3'b100, 0, 0);
    step(3'b100, 6'b10_00_00, 3'b000, 1, 1, 0, 2, 3'b100, 2, 1);
    step(3'b000, T_IDL, 3'b000, 1, 1, 1, 2, 3'b000, 2, 0);
    step(3'b011, T_NS, 3'b000, 1, 1, 0, 0, 3'b001, 2, 0);

    repeat (2) @(negedge HCLK);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
